serial_adder: RTL and testbench
===============================

// Module: serial_adder
// PURPOSE
//  Bit-serial WIDTH-bit adder: accepts two operands plus carry-in over a valid/ready
//  handshake and adds them LSB-first, one bit per clock.
//  Per-bit datapath: two HA instances plus an OR gate, forming a full adder, with a
//  registered carry. Presents sum/cout on a valid/ready output port.
//  Sits downstream of operand sources; minimal area for wide or slow arithmetic paths.
// PARAMETERS
//  WIDTH  8  operand/sum width in bits (>=2); sets cycle count per add
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operands a/b/cin valid
//  in_ready   out  1      block can accept operands (high only in IDLE)
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in
//  out_valid  out  1      sum/cout valid (high only in DONE)
//  out_ready  in   1      consumer accepts result
//  sum        out  WIDTH  result, a+b+cin mod 2^WIDTH
//  cout       out  1      carry-out of bit WIDTH-1
// BEHAVIOUR
//  - Reset (rst_n low, async): state=IDLE, bit counter=0, carry reg=0, sum=0,
//    cout=0, out_valid=0, in_ready=1 once reset is released.
//  - FSM IDLE/RUN/DONE.
//    - IDLE: in_ready=1. On in_valid&&in_ready: latch a, b into shift regs;
//      carry<=cin; cnt<=0; go to RUN.
//    - RUN: each edge, bit cnt = a_sh[0]^b_sh[0]^carry shifts into sum MSB
//      (sum shifts right).
//      carry <= majority(a_sh[0],b_sh[0],carry); a_sh,b_sh shift right; cnt++.
//      When cnt==WIDTH-1 that edge completes the last bit: cout<=carry-out; go to DONE.
//    - DONE: out_valid=1, sum/cout stable. On out_valid&&out_ready -> IDLE.
//  - Latency: accept at edge E; out_valid high after edge E+WIDTH (WIDTH clocks).
//  - Throughput: one add per WIDTH+2 cycles minimum. No same-cycle reload;
//    in_ready=0 in DONE.
//  - Backpressure: out_ready low holds DONE indefinitely; sum/cout/out_valid unchanged.
//  - in_valid/a/b/cin are ignored outside IDLE; inputs changing during RUN do not
//    affect the result.
//  - sum/cout retain the last result after the output handshake until the next
//    completion. sum is not valid while out_valid=0.
//  - Width rules: a, b, sum are WIDTH bits; the carry register is 1 bit; the counter
//    is $clog2(WIDTH) bits and never wraps past WIDTH-1.
//  - Reset mid-RUN or mid-DONE: the operation is discarded; all state and outputs
//    return to their reset values immediately.
// CONFIGURATION
//  SERIAL_ADDER_SUB_EN defined:
//    - Adds an input port `sub` (1 bit), sampled with the operands at input handshake.
//    - sub=1: b latched as ~b and the initial carry forced to 1, ignoring cin;
//      the block computes a-b.
//    - cout=1 means no borrow (a>=b, unsigned).
//    - sub=0 behaves exactly as the undefined build.
//  SERIAL_ADDER_SUB_EN undefined: no `sub` port; addition only.
// TESTING (WIDTH=8)
//  1. a=8'h0F, b=8'h01, cin=0 -> sum=8'h10, cout=0; out_valid exactly 8 clk after
//     accept edge.
//  2. a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1
//     -> sum=8'hFF, cout=1.
//  3. Backpressure: out_ready=0 for 5 cycles after out_valid -> sum/cout held,
//     in_ready=0. Then out_ready=1 -> IDLE next cycle, in_ready=1.
//  4. Input change mid-RUN: accept a=8'h12, b=8'h34; change a/b/in_valid during RUN
//     -> sum=8'h46, cout=0, no second accept.
//  5. rst_n low at cycle 4 of RUN -> out_valid=0, sum=0, cout=0 asynchronously.
//     After release, a=8'h01, b=8'h01 -> sum=8'h02.
//  6. SERIAL_ADDER_SUB_EN: sub=1, a=8'h07, b=8'h05 -> sum=8'h02, cout=1.
//     sub=1, a=8'h05, b=8'h07 -> sum=8'hFE, cout=0.

Source files
------------

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, LSB first, one bit per clock.
// Operands are taken on a valid/ready input handshake. The result is offered
// on a valid/ready output handshake.
// Per-bit datapath: two half adders plus an OR form a full adder. The carry
// between bits is held in a register.
// Optional build macro SERIAL_ADDER_SUB_EN adds a `sub` input. With sub=1 the
// block computes a-b; cout=1 then means no borrow.

module serial_adder_ha (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    logic [WIDTH-1:0]  a_sh, b_sh, s_sh;
    logic [CW-1:0]     cnt;
    logic              carry;

    // Operand conditioning: subtraction is a + ~b + 1.
    logic [WIDTH-1:0]  b_ld;
    logic              c_ld;
`ifdef SERIAL_ADDER_SUB_EN
    assign b_ld = sub ? ~b : b;
    assign c_ld = sub ? 1'b1 : cin;
`else
    assign b_ld = b;
    assign c_ld = cin;
`endif

    // One full adder built from two half adders on the current LSBs.
    logic hs0, hc0, fa_s, hc1, fa_c;
    serial_adder_ha u_ha0 (.x(a_sh[0]), .y(b_sh[0]), .s(hs0),  .c(hc0));
    serial_adder_ha u_ha1 (.x(hs0),     .y(carry),   .s(fa_s), .c(hc1));
    assign fa_c = hc0 | hc1;

    // Control FSM and serial datapath. The sum bits shift through s_sh.
    // The visible sum is updated only when the last bit completes, so it keeps
    // the previous result until the next completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            s_sh      <= '0;
            cnt       <= '0;
            carry     <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_sh     <= a;
                        b_sh     <= b_ld;
                        carry    <= c_ld;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
                    s_sh  <= {fa_s, s_sh[WIDTH-1:1]};
                    carry <= fa_c;
                    if (cnt == LAST) begin
                        sum       <= {fa_s, s_sh[WIDTH-1:1]};
                        cout      <= fa_c;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8). It uses hand-computed sums.
module tb_serial_adder;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0, b = '0;
    logic         cin = 1'b0;
    logic         sub_r = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub_r),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Present operands on a falling edge and accept them on the next rising edge.
    task automatic send(input logic [W-1:0] ai, input logic [W-1:0] bi,
                        input logic ci, input logic si);
        @(negedge clk);
        a = ai; b = bi; cin = ci; sub_r = si; in_valid = 1'b1;
        chk("in_ready_at_send", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Expect out_valid to rise exactly W edges after the accept edge.
    task automatic wait_res(input string tag, input logic [W-1:0] es, input logic ec);
        for (int i = 1; i <= W; i++) begin
            @(posedge clk); #1;
            if (i == W - 1) chk({tag, "_early"}, out_valid, 0);
        end
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_sum"}, sum, es);
        chk({tag, "_cout"}, cout, ec);
        chk({tag, "_in_ready"}, in_ready, 0);
    endtask

    task automatic drain(input string tag);
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        chk({tag, "_drain_valid"}, out_valid, 0);
        chk({tag, "_drain_in_ready"}, in_ready, 1);
    endtask

    initial begin
        // Check the reset state.
        #12;
        chk("rst_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        #1 chk("rst_in_ready", in_ready, 1);

        // Test 1: basic add and latency.
        send(8'h0F, 8'h01, 1'b0, 1'b0);
        wait_res("t1", 8'h10, 1'b0);
        drain("t1");

        // Test 2: carry out of the top bit.
        send(8'hFF, 8'h01, 1'b0, 1'b0);
        wait_res("t2a", 8'h00, 1'b1);
        drain("t2a");
        chk("t2a_retain_cout", cout, 1);
        send(8'hFF, 8'hFF, 1'b1, 1'b0);
        wait_res("t2b", 8'hFF, 1'b1);

        // Test 3: backpressure holds DONE.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("t3_hold_valid", out_valid, 1);
            chk("t3_hold_sum", sum, 8'hFF);
            chk("t3_hold_in_ready", in_ready, 0);
        end
        drain("t3");

        // Test 4: inputs change during RUN. in_valid stays high through DONE.
        send(8'h12, 8'h34, 1'b0, 1'b0);
        a = 8'hFF; b = 8'hFF; cin = 1'b1; in_valid = 1'b1;
        wait_res("t4", 8'h46, 1'b0);
        drain("t4");
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("t4_no_reaccept", in_ready, 1);
        chk("t4_retain_sum", sum, 8'h46);

        // Test 5: async reset during RUN.
        send(8'hAA, 8'h11, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", out_valid, 0);
        chk("t5_rst_sum", sum, 0);
        chk("t5_rst_cout", cout, 0);
        @(negedge clk); rst_n = 1'b1;
        send(8'h01, 8'h01, 1'b0, 1'b0);
        wait_res("t5", 8'h02, 1'b0);
        drain("t5");

`ifdef SERIAL_ADDER_SUB_EN
        // Test 6: subtraction, with and without borrow.
        send(8'h07, 8'h05, 1'b0, 1'b1);
        wait_res("t6a", 8'h02, 1'b1);
        drain("t6a");
        send(8'h05, 8'h07, 1'b1, 1'b1);
        wait_res("t6b", 8'hFE, 1'b0);
        drain("t6b");
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
